// File: rtl/soc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// soc_ctrl_pkg
// Shared types and helpers for the soc_ctrl reset sequencing slice.
//   rst_seq_state_e : state encoding of the power-up / power-down sequencer
//   rst_seq_idx_w   : width of a domain index (at least one bit)
//   rst_seq_busy    : states in which a sequencing walk is in progress
// -----------------------------------------------------------------------------
package soc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_REL      = 4'd1,
        ST_WAIT_RDY = 4'd2,
        ST_GAP      = 4'd3,
        ST_UP       = 4'd4,
        ST_DIS      = 4'd5,
        ST_DGAP     = 4'd6,
        ST_ASRT     = 4'd7,
        ST_ERR      = 4'd8
    } rst_seq_state_e;

    // A single domain still needs a one-bit index so ports never collapse to zero width.
    function automatic int unsigned rst_seq_idx_w(input int unsigned num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

    // UP and ERR are resting states; IDLE is the quiescent state.
    function automatic logic rst_seq_busy(input rst_seq_state_e st);
        return (st == ST_REL)  || (st == ST_WAIT_RDY) || (st == ST_GAP) ||
               (st == ST_DIS)  || (st == ST_DGAP)     || (st == ST_ASRT);
    endfunction

endpackage

// File: rtl/soc_ctrl_counter.sv
// -----------------------------------------------------------------------------
// soc_ctrl_counter
// Small saturating cycle counter used by the reset sequencer for gap and
// timeout measurement. Counts up from zero (UP_COUNT=1) or down from
// MAX_COUNT (UP_COUNT=0) while enabled; clr_i reloads the start value.
//   clk_i    in  1  clock
//   rst_ni   in  1  synchronous active-low reset
//   clr_i    in  1  reload start value (wins over en_i)
//   en_i     in  1  advance one step this cycle
//   last_o   out 1  counter sits on its final counted step (MAX_COUNT-1 up, 1 down)
// -----------------------------------------------------------------------------
module soc_ctrl_counter #(
    parameter int unsigned MAX_COUNT = 8,
    parameter bit          UP_COUNT  = 1'b1,
    localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_INIT = UP_COUNT ? '0 : CNT_MAX;
    localparam logic [CNT_W-1:0] CNT_END  = UP_COUNT ? CNT_MAX : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = UP_COUNT ? CNT_W'(MAX_COUNT - 1) : CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Saturating at the end value keeps the counter from wrapping if a caller
    // leaves it enabled past its last step.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= CNT_INIT;
        end else if (clr_i) begin
            count <= CNT_INIT;
        end else if (en_i && (count != CNT_END)) begin
            count <= UP_COUNT ? (count + CNT_W'(1)) : (count - CNT_W'(1));
        end
    end

    assign last_o = (count == CNT_LAST);

endmodule

// File: rtl/soc_ctrl_rst_sequencer.sv
// -----------------------------------------------------------------------------
// soc_ctrl_rst_sequencer
// Orders power-up and power-down of NUM_DOMAINS clock/reset domains, each of
// which sits behind a soc_ctrl_clk_rst_delay_gen. Power-up releases reset and
// clock enable per domain in ascending order, waits for the domain's ready and
// then inserts a gap; power-down walks the domains in reverse, dropping the
// clock enable first and the reset a gap later.
//   clk_i        in  1     reference clock (single clock domain)
//   rst_ni       in  1     synchronous active-low reset
//   start_i      in  1     level, request power-up (looked at in IDLE only)
//   stop_i       in  1     level, request power-down / abort (any non-IDLE state)
//   domain_en_i  in  N     per-domain include mask, captured when start is taken
//   ready_i      in  N     per-domain ready from the delay generators
//   rst_no       out N     per-domain active-low reset
//   clk_en_o     out N     per-domain clock enable
//   busy_o       out 1     a sequencing walk is in progress
//   done_o       out 1     all enabled domains are up
//   err_o        out 1     a domain failed to become ready in time
//   err_idx_o    out IW    index of the domain that timed out
// -----------------------------------------------------------------------------
module soc_ctrl_rst_sequencer
    import soc_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic                                  stop_i,
    input  logic [NUM_DOMAINS-1:0]                domain_en_i,
    input  logic [NUM_DOMAINS-1:0]                ready_i,
    output logic [NUM_DOMAINS-1:0]                rst_no,
    output logic [NUM_DOMAINS-1:0]                clk_en_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o,
    output logic [rst_seq_idx_w(NUM_DOMAINS)-1:0] err_idx_o
);

    localparam int unsigned     IDX_W    = rst_seq_idx_w(NUM_DOMAINS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    rst_seq_state_e           state;
    logic [IDX_W-1:0]         idx;
    logic [NUM_DOMAINS-1:0]   mask;

    logic gap_run;
    logic gap_last;
    logic tmo_run;
    logic tmo_last;

    // Both counters are held cleared outside the states that use them, so
    // every entry into GAP/DGAP or WAIT_RDY starts from zero, including the
    // entries that follow an abort.
    assign gap_run = (state == ST_GAP) || (state == ST_DGAP);
    assign tmo_run = (state == ST_WAIT_RDY);

    soc_ctrl_counter #(
        .MAX_COUNT (GAP_CYCLES),
        .UP_COUNT  (1'b1)
    ) u_gap_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!gap_run),
        .en_i   (gap_run),
        .last_o (gap_last)
    );

    soc_ctrl_counter #(
        .MAX_COUNT (TIMEOUT_CYCLES),
        .UP_COUNT  (1'b1)
    ) u_tmo_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!tmo_run),
        .en_i   (tmo_run),
        .last_o (tmo_last)
    );

    // Sequencer FSM. Every output is a register updated on the same edge as
    // the state change, so busy_o/done_o always describe the state being
    // entered. A domain's clock enable is only ever raised together with its
    // reset release and is dropped a full gap before the reset is asserted
    // again, which keeps clk_en_o[i] implying rst_no[i].
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            idx       <= '0;
            mask      <= '0;
            rst_no    <= '0;
            clk_en_o  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A simultaneous stop request blocks the power-up.
                    if (start_i && !stop_i) begin
                        mask   <= domain_en_i;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= ST_REL;
                    end
                end

                ST_REL: begin
                    if (stop_i) begin
                        state <= ST_DIS;
                    end else if (mask[idx]) begin
                        rst_no[idx]   <= 1'b1;
                        clk_en_o[idx] <= 1'b1;
                        state         <= ST_WAIT_RDY;
                    end else begin
                        // Excluded domains still consume a gap so the spacing
                        // between the remaining domains does not depend on the mask.
                        state <= ST_GAP;
                    end
                end

                ST_WAIT_RDY: begin
                    // Ready is checked before the timeout so a ready arriving on
                    // the last allowed cycle still counts as success.
                    if (stop_i) begin
                        state <= ST_DIS;
                    end else if (ready_i[idx]) begin
                        state <= ST_GAP;
                    end else if (tmo_last) begin
                        err_o     <= 1'b1;
                        err_idx_o <= idx;
                        busy_o    <= 1'b0;
                        state     <= ST_ERR;
                    end
                end

                ST_GAP: begin
                    if (stop_i) begin
                        state <= ST_DIS;
                    end else if (gap_last) begin
                        if (idx == IDX_LAST) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= ST_UP;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_REL;
                        end
                    end
                end

                ST_UP: begin
                    if (stop_i) begin
                        done_o <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= ST_DIS;
                    end
                end

                ST_DIS: begin
                    if (mask[idx]) begin
                        clk_en_o[idx] <= 1'b0;
                    end
                    state <= ST_DGAP;
                end

                ST_DGAP: begin
                    if (gap_last) begin
                        state <= ST_ASRT;
                    end
                end

                ST_ASRT: begin
                    rst_no[idx] <= 1'b0;
                    if (idx == '0) begin
                        // Reaching IDLE is the only way an error indication is retired.
                        mask   <= '0;
                        busy_o <= 1'b0;
                        err_o  <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        idx   <= idx - IDX_W'(1);
                        state <= ST_DIS;
                    end
                end

                ST_ERR: begin
                    // Teardown restarts from the domain that timed out; everything
                    // above it was never released.
                    if (stop_i) begin
                        idx    <= err_idx_o;
                        busy_o <= 1'b1;
                        state  <= ST_DIS;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= rst_seq_busy(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_ctrl_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_soc_ctrl_rst_sequencer
// Directed bench for the reset sequencer. Each ready_i bit follows clk_en_o
// through a 50-cycle delay line (optionally forced low), mimicking the delay
// generators. Expected output edges, with their spacing in cycles, are queued
// before each scenario and matched in order by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_soc_ctrl_rst_sequencer;

    localparam int N       = 4;
    localparam int GAP     = 8;
    localparam int TMO     = 256;
    localparam int RDY_DLY = 50;

    // Event kinds seen by the monitor.
    localparam int K_RST  = 0;
    localparam int K_CLK  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic [N-1:0] domain_en;
    logic [N-1:0] ready;
    logic [N-1:0] rst_no;
    logic [N-1:0] clk_en;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_idx;

    logic [N-1:0] stuck = '0;
    logic [N-1:0] dly [RDY_DLY];

    typedef struct {
        int kind;
        int idx;
        int val;
        int delta;
    } evt_t;

    evt_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_cyc     = 0;
    bit mon_en       = 1'b0;

    soc_ctrl_rst_sequencer #(
        .NUM_DOMAINS    (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .domain_en_i (domain_en),
        .ready_i     (ready),
        .rst_no      (rst_no),
        .clk_en_o    (clk_en),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_idx_o   (err_idx)
    );

    always #5 clk = ~clk;

    // Delay generator stand-in: ready follows the clock enable 50 cycles late.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RDY_DLY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= clk_en;
            for (int i = 1; i < RDY_DLY; i++) dly[i] <= dly[i-1];
        end
    end

    assign ready = dly[RDY_DLY-1] & ~stuck;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic [N-1:0] en);
        start     = s;
        stop      = p;
        domain_en = en;
    endtask

    task automatic pushExpected(input int kind, input int idx, input int val, input int delta);
        evt_t e;
        e.kind  = kind;
        e.idx   = idx;
        e.val   = val;
        e.delta = delta;
        sb.push_back(e);
    endtask

    // Match one observed edge against the head of the scoreboard; a negative
    // expected delta means the spacing to the previous edge is not checked.
    task automatic seeEvent(input int kind, input int idx, input int val);
        evt_t e;
        int   code;
        code = kind * 100 + idx * 10 + val;
        if (sb.size() == 0) begin
            checkOutput("sb_unexpected_event", code, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            checkOutput("sb_event", code, e.kind * 100 + e.idx * 10 + e.val);
            if (e.delta >= 0) checkOutput("sb_spacing", cyc - last_cyc, e.delta);
        end
        last_cyc = cyc;
    endtask

    // Output edge monitor. Edges on one clock are reported in a fixed order:
    // resets by index, clock enables by index, then done, then err.
    initial begin
        logic [N-1:0] prev_rst;
        logic [N-1:0] prev_clk;
        logic         prev_done;
        logic         prev_err;
        prev_rst  = '0;
        prev_clk  = '0;
        prev_done = 1'b0;
        prev_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                for (int i = 0; i < N; i++)
                    if (rst_no[i] !== prev_rst[i]) seeEvent(K_RST, i, int'(rst_no[i]));
                for (int i = 0; i < N; i++)
                    if (clk_en[i] !== prev_clk[i]) seeEvent(K_CLK, i, int'(clk_en[i]));
                if (done !== prev_done) seeEvent(K_DONE, 0, int'(done));
                if (err !== prev_err) seeEvent(K_ERR, 0, int'(err));
                prev_rst  = rst_no;
                prev_clk  = clk_en;
                prev_done = done;
                prev_err  = err;
            end
        end
    end

    task automatic pulseStart(input logic [N-1:0] en);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, en);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic pulseStop();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic waitDone(input string tag);
        for (int k = 0; k < 2000 && done !== 1'b1; k++) @(negedge clk);
        checkOutput(tag, done, 1'b1);
    endtask

    task automatic waitIdle(input string tag);
        for (int k = 0; k < 2000 && busy !== 1'b0; k++) @(negedge clk);
        checkOutput(tag, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_rst_no", rst_no, 4'b0000);
        checkOutput("reset_clk_en", clk_en, 4'b0000);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_err_idx", err_idx, 2'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Full power-up; domain_en is cleared right after acceptance
        pushExpected(K_RST, 0, 1, -1);  pushExpected(K_CLK, 0, 1, 0);
        pushExpected(K_RST, 1, 1, 60);  pushExpected(K_CLK, 1, 1, 0);
        pushExpected(K_RST, 2, 1, 60);  pushExpected(K_CLK, 2, 1, 0);
        pushExpected(K_RST, 3, 1, 60);  pushExpected(K_CLK, 3, 1, 0);
        pushExpected(K_DONE, 0, 1, 59);
        pulseStart(4'b1111);
        checkOutput("pwrup_busy", busy, 1'b1);
        waitDone("pwrup_done");
        checkOutput("pwrup_busy_in_up", busy, 1'b0);
        checkOutput("pwrup_rst_no", rst_no, 4'b1111);
        repeat (2) @(negedge clk);
        checkOutput("pwrup_sb_empty", sb.size(), 0);

        // Power-down from UP
        pushExpected(K_DONE, 0, 0, -1);
        pushExpected(K_CLK, 3, 0, 1);  pushExpected(K_RST, 3, 0, 9);
        pushExpected(K_CLK, 2, 0, 1);  pushExpected(K_RST, 2, 0, 9);
        pushExpected(K_CLK, 1, 0, 1);  pushExpected(K_RST, 1, 0, 9);
        pushExpected(K_CLK, 0, 0, 1);  pushExpected(K_RST, 0, 0, 9);
        pulseStop();
        checkOutput("pwrdn_busy", busy, 1'b1);
        waitIdle("pwrdn_idle");
        checkOutput("pwrdn_rst_no", rst_no, 4'b0000);
        checkOutput("pwrdn_sb_empty", sb.size(), 0);
        repeat (60) @(negedge clk);

        // Partial mask: domains 0 and 2 skipped
        pushExpected(K_RST, 1, 1, -1);  pushExpected(K_CLK, 1, 1, 0);
        pushExpected(K_RST, 3, 1, 69);  pushExpected(K_CLK, 3, 1, 0);
        pushExpected(K_DONE, 0, 1, 59);
        pulseStart(4'b1010);
        waitDone("mask_done");
        checkOutput("mask_rst_no", rst_no, 4'b1010);
        checkOutput("mask_sb_empty", sb.size(), 0);
        pushExpected(K_DONE, 0, 0, -1);
        pushExpected(K_CLK, 3, 0, 1);   pushExpected(K_RST, 3, 0, 9);
        pushExpected(K_CLK, 1, 0, 11);  pushExpected(K_RST, 1, 0, 9);
        pulseStop();
        waitIdle("mask_idle");
        checkOutput("mask_pwrdn_sb_empty", sb.size(), 0);
        repeat (60) @(negedge clk);

        // Ready of domain 2 never arrives
        stuck = 4'b0100;
        pushExpected(K_RST, 0, 1, -1);  pushExpected(K_CLK, 0, 1, 0);
        pushExpected(K_RST, 1, 1, 60);  pushExpected(K_CLK, 1, 1, 0);
        pushExpected(K_RST, 2, 1, 60);  pushExpected(K_CLK, 2, 1, 0);
        pushExpected(K_ERR, 0, 1, TMO);
        pulseStart(4'b1111);
        for (int k = 0; k < 2000 && err !== 1'b1; k++) @(negedge clk);
        checkOutput("tmo_err", err, 1'b1);
        checkOutput("tmo_err_idx", err_idx, 2'd2);
        checkOutput("tmo_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("tmo_held_rst_no", rst_no, 4'b0111);
        checkOutput("tmo_held_clk_en", clk_en, 4'b0111);
        checkOutput("tmo_sb_empty", sb.size(), 0);
        pushExpected(K_CLK, 2, 0, -1);  pushExpected(K_RST, 2, 0, 9);
        pushExpected(K_CLK, 1, 0, 1);   pushExpected(K_RST, 1, 0, 9);
        pushExpected(K_CLK, 0, 0, 1);   pushExpected(K_RST, 0, 0, 9);
        pushExpected(K_ERR, 0, 0, 0);
        pulseStop();
        checkOutput("tmo_teardown_err_held", err, 1'b1);
        waitIdle("tmo_idle");
        checkOutput("tmo_err_cleared", err, 1'b0);
        checkOutput("tmo_teardown_sb_empty", sb.size(), 0);
        stuck = 4'b0000;
        repeat (60) @(negedge clk);

        // Abort while waiting for domain 1
        pushExpected(K_RST, 0, 1, -1);  pushExpected(K_CLK, 0, 1, 0);
        pushExpected(K_RST, 1, 1, 60);  pushExpected(K_CLK, 1, 1, 0);
        pushExpected(K_CLK, 1, 0, -1);  pushExpected(K_RST, 1, 0, 9);
        pushExpected(K_CLK, 0, 0, 1);   pushExpected(K_RST, 0, 0, 9);
        pulseStart(4'b1111);
        for (int k = 0; k < 500 && rst_no[1] !== 1'b1; k++) @(negedge clk);
        checkOutput("abort_dom1_released", rst_no[1], 1'b1);
        repeat (20) @(negedge clk);
        pulseStop();
        waitIdle("abort_idle");
        checkOutput("abort_rst_no", rst_no, 4'b0000);
        checkOutput("abort_sb_empty", sb.size(), 0);
        repeat (60) @(negedge clk);

        // Reset in the middle of a power-up, with start and stop both held
        pushExpected(K_RST, 0, 1, -1);  pushExpected(K_CLK, 0, 1, 0);
        pushExpected(K_RST, 1, 1, 60);  pushExpected(K_CLK, 1, 1, 0);
        pushExpected(K_RST, 0, 0, -1);  pushExpected(K_RST, 1, 0, 0);
        pushExpected(K_CLK, 0, 0, 0);   pushExpected(K_CLK, 1, 0, 0);
        pulseStart(4'b1111);
        for (int k = 0; k < 500 && rst_no[1] !== 1'b1; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'b1111);
        @(negedge clk);
        checkOutput("mrst_rst_no", rst_no, 4'b0000);
        checkOutput("mrst_clk_en", clk_en, 4'b0000);
        checkOutput("mrst_busy", busy, 1'b0);
        checkOutput("mrst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("mrst_stop_wins_busy", busy, 1'b0);
        checkOutput("mrst_stop_wins_rst_no", rst_no, 4'b0000);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        checkOutput("mrst_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
